// File: rtl/dice_pkg.sv
// Shared definitions for the dice display driver.
//   SEG_0..SEG_9, SEG_BLANK : lit vectors {dp,g,f,e,d,c,b,a}, 1 = segment lit
//   dice_state_e            : binary-to-decimal converter FSM states
//   seg7_encode()           : 4-bit digit -> 8-bit lit vector (dp never lit)
package dice_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [6:0] VALUE_MAX = 7'd99;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } dice_state_e;

    // Digits outside 0..9 cannot occur; they map to a dark digit.
    function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
        logic [7:0] lit;
        case (digit)
            4'd0:    lit = SEG_0;
            4'd1:    lit = SEG_1;
            4'd2:    lit = SEG_2;
            4'd3:    lit = SEG_3;
            4'd4:    lit = SEG_4;
            4'd5:    lit = SEG_5;
            4'd6:    lit = SEG_6;
            4'd7:    lit = SEG_7;
            4'd8:    lit = SEG_8;
            4'd9:    lit = SEG_9;
            default: lit = SEG_BLANK;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/dice_display_driver_bin2bcd_seq.sv
// Sequential binary (0..99) to two-digit decimal converter.
// Repeated subtract-by-ten; a new strobe at any time restarts with the new value.
//   clk, rst_n   : clock, async active-low reset
//   value_in     : binary value, clamped to 99
//   value_valid  : single-cycle load strobe
//   ones, tens   : committed digits (both updated on the same edge)
//   loaded       : set by the first completed conversion, held until reset
//   busy         : high from the load edge through the commit cycle
module bin2bcd_seq
    import dice_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] value_in,
    input  logic       value_valid,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       loaded,
    output logic       busy
);

    dice_state_e state_r, state_next_s;
    logic [6:0]  rem_r, rem_next_s;
    logic [3:0]  tcnt_r, tcnt_next_s;
    logic        commit_s;
    logic [3:0]  ones_r, tens_r;
    logic        loaded_r, busy_r;

    // Next-state logic: load/restart on strobe, otherwise subtract until below ten.
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = rem_r;
        tcnt_next_s  = tcnt_r;
        commit_s     = 1'b0;
        if (value_valid) begin
            state_next_s = ST_CONVERT;
            rem_next_s   = (value_in > VALUE_MAX) ? VALUE_MAX : value_in;
            tcnt_next_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_CONVERT: begin
                    if (rem_r >= 7'd10) begin
                        rem_next_s  = rem_r - 7'd10;
                        tcnt_next_s = tcnt_r + 4'd1;
                    end else begin
                        commit_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Converter state, working registers and committed digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rem_r    <= 7'd0;
            tcnt_r   <= 4'd0;
            ones_r   <= 4'd0;
            tens_r   <= 4'd0;
            loaded_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rem_r   <= rem_next_s;
            tcnt_r  <= tcnt_next_s;
            // Covering the current state as well keeps busy up through the commit cycle.
            busy_r  <= (state_next_s == ST_CONVERT) || (state_r == ST_CONVERT);
            if (commit_s) begin
                ones_r   <= rem_r[3:0];
                tens_r   <= tcnt_r;
                loaded_r <= 1'b1;
            end else begin
                ones_r   <= ones_r;
                tens_r   <= tens_r;
                loaded_r <= loaded_r;
            end
        end
    end

    assign ones   = ones_r;
    assign tens   = tens_r;
    assign loaded = loaded_r;
    assign busy   = busy_r;

endmodule

// File: rtl/dice_display_driver.sv
// Two-digit multiplexed 7-segment display driver.
//   REFRESH_CYCLES : clock cycles per digit phase (>= 2)
//   clk, rst_n     : clock, async active-low reset
//   value_in       : binary roll result (clamped to 99)
//   value_valid    : load strobe for value_in
//   blank          : dark display while high, digits retained
//   seg_pol        : level at which a segment output is lit
//   com_pol        : level at which a common output is active
//   seg_out        : {dp,g,f,e,d,c,b,a}
//   com_out        : [0] ones common, [1] tens common
//   com_oe         : common output enables (11 after the first edge out of reset)
//   busy           : conversion in progress
module dice_display_driver
    import dice_pkg::*;
#(
    parameter int REFRESH_CYCLES = 10000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] value_in,
    input  logic       value_valid,
    input  logic       blank,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [7:0] seg_out,
    output logic [1:0] com_out,
    output logic [1:0] com_oe,
    output logic       busy
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    logic [3:0]    ones_s, tens_s;
    logic          loaded_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic          phase_r, phase_next_s;
    logic [7:0]    lit_r, lit_next_s;
    logic [1:0]    act_r, act_next_s;
    logic [1:0]    com_oe_r;

    bin2bcd_seq u_bin2bcd (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .ones        (ones_s),
        .tens        (tens_s),
        .loaded      (loaded_s),
        .busy        (busy)
    );

    // Refresh counter wrap and phase toggle.
    always_comb begin
        cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        phase_next_s = phase_r;
        if (cnt_r == CNT_LAST) begin
            cnt_next_s   = {CW{1'b0}};
            phase_next_s = ~phase_r;
        end else begin
            cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            phase_next_s = phase_r;
        end
    end

    // Lit/active vectors are derived from the next counter state so the
    // registered vectors line up with the counter (count 0 is the dark cycle).
    always_comb begin
        lit_next_s = SEG_BLANK;
        act_next_s = 2'b00;
        if (blank || !loaded_s || (cnt_next_s == {CW{1'b0}})) begin
            lit_next_s = SEG_BLANK;
            act_next_s = 2'b00;
        end else if (phase_next_s == 1'b0) begin
            lit_next_s = seg7_encode(ones_s);
            act_next_s = 2'b01;
        end else if (tens_s != 4'd0) begin
            lit_next_s = seg7_encode(tens_s);
            act_next_s = 2'b10;
        end else begin
            // Leading zero: tens phase stays dark.
            lit_next_s = SEG_BLANK;
            act_next_s = 2'b00;
        end
    end

    // Refresh state and display vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            phase_r  <= 1'b0;
            lit_r    <= SEG_BLANK;
            act_r    <= 2'b00;
            com_oe_r <= 2'b00;
        end else begin
            cnt_r    <= cnt_next_s;
            phase_r  <= phase_next_s;
            lit_r    <= lit_next_s;
            act_r    <= act_next_s;
            com_oe_r <= 2'b11;
        end
    end

    // Polarity is applied after the registers so pin changes take effect at once.
    assign seg_out = lit_r ~^ {8{seg_pol}};
    assign com_out = act_r ~^ {2{com_pol}};
    assign com_oe  = com_oe_r;

endmodule

// File: doc/dice_display_driver.md
# dice_display_driver

Two-digit multiplexed 7-segment display driver for the dice roller. Sits directly downstream of the roll engine: takes the rolled result as a binary value (0–99), converts it to two decimal digits with a sequential subtract-by-ten loop, and time-multiplexes the tens and ones digits onto the shared segment bus (`uo_out`) and the two common lines (`uio_out[1:0]`). Segment and common polarity are selectable from pins so that any display type can be used.

## Interface
- `REFRESH_CYCLES`, default 10000: clock cycles per digit phase; minimum 2. Benches use 8.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `value_in`  in  7  binary roll result; values above 99 are clamped to 99.
- `value_valid`  in  1  single-cycle load strobe for `value_in`.
- `blank`  in  1  while high, the display shows nothing; digit registers are kept.
- `seg_pol`  in  1  a segment is lit when its output equals `seg_pol` (`uio_in[6]`).
- `com_pol`  in  1  a common is active when it equals `com_pol` (`uio_in[7]`).
- `seg_out`  out  8  segments {dp,g,f,e,d,c,b,a}; dp is never lit.
- `com_out`  out  2  [0] = ones common, [1] = tens common.
- `com_oe`  out  2  output enables for the commons.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- FSM states are IDLE and CONVERT.
- IDLE, `value_valid`=1: latch min(`value_in`, 99) into the remainder register, clear the tens counter, go to CONVERT.
- CONVERT, remainder ≥ 10: remainder −= 10, tens += 1.
- CONVERT, remainder < 10: commit ones = remainder and tens = tens counter into the digit registers in a single edge, so both digits change together. Set `loaded`=1 and return to IDLE.
- `value_valid` in CONVERT restarts the conversion with the new value (latest value wins). The old digits stay displayed.
- The refresh counter runs 0..`REFRESH_CYCLES`−1 and then wraps. The `phase` bit toggles on each wrap (0 = ones, 1 = tens).
- Counter == 0 is a dead cycle: both commons are inactive and no segments are lit (anti-ghosting).
- Other cycles:
  - The phase's common is active and the other is inactive.
  - Segments show the phase digit: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (lit-vector hex).
- Leading-zero blanking: if tens == 0, the tens phase has its common inactive and no segments lit.
- `blank`=1 or `loaded`=0: both commons inactive and no segments lit in every cycle. The refresh counter keeps running.
- Arithmetic: remainder is 7 bits and tens is 4 bits. Neither can overflow because of the clamp.

## Timing
- All state is registered: FSM, remainder, tens counter, digit registers, refresh counter, `phase`, `loaded`, internal lit vector (8 bits), internal common-active vector (2 bits).
- Polarity is applied combinationally after the registers:
  - `seg_out` = lit XNOR {8{`seg_pol`}}
  - `com_out` = act XNOR {2{`com_pol`}}
  - A polarity pin change shows on the outputs in the same cycle.
- Reset values:
  - FSM = IDLE; all counters and digit registers = 0; `phase`=0; `loaded`=0; `busy`=0.
  - lit = 0, act = 0, so `seg_out` = {8{~`seg_pol`}} and `com_out` = {2{~`com_pol`}}.
  - `com_oe` = 00. It becomes 11 on the first clock edge after reset release and stays 11.
- Conversion latency for a strobe at edge N with clamped value v:
  - CONVERT is entered at N+1.
  - The digits commit at edge N+1+⌊v/10⌋+1.
  - `busy` is high from N+1 through the commit cycle.
- Digit changes reach lit/act at the next refresh-counter update, at most one cycle later.
- Reset asserted mid-conversion or mid-refresh clears everything immediately. The display is blank until the next completed conversion.

## Structure
- Package `dice_pkg` holds:
  - the 7-segment digit constants (`SEG_0`..`SEG_9`, `SEG_BLANK`)
  - the FSM state typedef
  - a `seg7_encode` function (4-bit digit → 8-bit lit vector).
- One sub-module is natural: `bin2bcd_seq`, the IDLE/CONVERT subtract loop with the valid/restart/busy handshake. The top level keeps the refresh counter, phase logic, blanking and polarity logic.

## Test plan
- Reset with `seg_pol`=1, `com_pol`=0 → `seg_out`=00, `com_out`=11, `com_oe`=00, `busy`=0. After release `com_oe`=11 and the display stays blank.
- `value_in`=42 strobe → `busy` high for 6 cycles, digits commit. Ones phase: `seg_out`=5B, `com_out`=10. Tens phase: `seg_out`=66, `com_out`=01. Dead cycle between them: `com_out`=11, `seg_out`=00.
- `value_in`=7 → ones phase shows 07. Tens phase: `seg_out`=00 and both commons inactive.
- `value_in`=120 → clamped: both phases show 6F, commit 11 cycles after the strobe.
- Strobe 99, then strobe 5 two cycles later → the final display is "5" only. Any digits shown in between are the previous value (blank after reset). Then toggle `seg_pol` to 0 → `seg_out` inverts in the same cycle.
- Assert `rst_n`=0 mid-conversion, then assert `blank` after a load → outputs return to the reset values immediately. With `blank`=1 the display is dark; deasserting `blank` restores the last digits without a new strobe.
